// File: rtl/settle_latch_pkg.sv
// settle_latch_pkg: shared lane state encoding, enable-mode constants and counter sizing.
`default_nettype none

package settle_latch_pkg;

    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_SETTLE = 2'd1,
        S_TRACK  = 2'd2
    } lane_state_t;

    localparam logic MODE_EXTERNAL = 1'b0;
    localparam logic MODE_DERIVED  = 1'b1;

    // Settle counter width: clog2(settle+1), never below one bit.
    function automatic int cnt_width(input int settle);
        int w;
        w = $clog2(settle + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/settle_latch_chan.sv
// settle_latch_chan: one lane -- enable synchroniser, derived-enable flop, settle FSM and output register.
`default_nettype none

module settle_latch_chan
    import settle_latch_pkg::*;
#(
    parameter int              WIDTH       = 8,
    parameter int              SETTLE      = 3,
    parameter int              SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_mode,
    input  logic             i_force_hold,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_en_n,
    output logic [WIDTH-1:0] o_d,
    output logic             o_valid,
    output logic             o_pulse
);

    localparam int             CW           = cnt_width(SETTLE);
    localparam logic [CW-1:0]  c_SETTLE_CNT = CW'(SETTLE);
    localparam logic [CW-1:0]  c_CNT_ONE    = CW'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_der;
    lane_state_t            r_state;
    logic [CW-1:0]          r_cnt;
    logic [WIDTH-1:0]       r_snap;
    logic [WIDTH-1:0]       r_d;
    logic                   r_valid;
    logic                   r_pulse;
    logic                   w_en_s;

    // A mode change presets both enable pipelines to "disabled" so the new source starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_der  <= 1'b1;
        end else if (i_force_hold) begin
            r_sync <= '1;
            r_der  <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_en_n};
            r_der  <= i_d[0];
        end
    end

    assign w_en_s = (i_mode == MODE_DERIVED) ? r_der : r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
            r_snap  <= '0;
            r_d     <= RESET_VAL;
            r_valid <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (i_force_hold) begin
                r_state <= S_HOLD;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_HOLD: begin
                        if (!w_en_s) begin
                            if (SETTLE == 0) begin
                                r_d     <= i_d;
                                r_pulse <= 1'b1;
                                r_valid <= 1'b1;
                                r_state <= S_TRACK;
                            end else begin
                                r_snap  <= i_d;
                                r_cnt   <= c_CNT_ONE;
                                r_state <= S_SETTLE;
                            end
                        end
                    end
                    S_SETTLE: begin
                        // Priority: deassert beats restart beats capture.
                        if (w_en_s) begin
                            r_cnt   <= '0;
                            r_state <= S_HOLD;
                        end else if (i_d != r_snap) begin
                            r_snap <= i_d;
                            r_cnt  <= c_CNT_ONE;
                        end else if (r_cnt == c_SETTLE_CNT) begin
                            r_d     <= r_snap;
                            r_pulse <= 1'b1;
                            r_valid <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= S_TRACK;
                        end else if (r_cnt != c_SETTLE_CNT) begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    S_TRACK: begin
                        if (w_en_s) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_d <= i_d;
                        end
                    end
                    default: begin
                        r_state <= S_HOLD;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_d     = r_d;
    assign o_valid = r_valid;
    assign o_pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/settle_latch_array.sv
// settle_latch_array: CHANNELS independent settle-then-capture lanes with shared mode-change hold.
`default_nettype none

module settle_latch_array
    import settle_latch_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               CHANNELS    = 4,
    parameter int               SETTLE      = 3,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [CHANNELS*WIDTH-1:0] d_in,
    input  logic [CHANNELS-1:0]       en_n_in,
    output logic [CHANNELS*WIDTH-1:0] d_out,
    output logic [CHANNELS-1:0]       valid_out,
    output logic [CHANNELS-1:0]       capture_pulse
);

    logic r_mode_q;
    logic w_mode_chg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_q <= MODE_EXTERNAL;
        end else begin
            r_mode_q <= mode;
        end
    end

    assign w_mode_chg = mode ^ r_mode_q;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        settle_latch_chan #(
            .WIDTH       (WIDTH),
            .SETTLE      (SETTLE),
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_VAL   (RESET_VAL)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_mode       (mode),
            .i_force_hold (w_mode_chg),
            .i_d          (d_in[k*WIDTH +: WIDTH]),
            .i_en_n       (en_n_in[k]),
            .o_d          (d_out[k*WIDTH +: WIDTH]),
            .o_valid      (valid_out[k]),
            .o_pulse      (capture_pulse[k])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_settle_latch_array.sv
// tb_settle_latch_array: directed checks of settle, restart, early deassert, track/hold, reset and derived mode.
`default_nettype none

module tb_settle_latch_array;

    logic        clk;
    logic        rst_n;
    logic        mode,  mode0;
    logic [31:0] d_in,  d_in0;
    logic [3:0]  en_n,  en_n0;
    logic [31:0] d_out, d_out0;
    logic [3:0]  valid, valid0;
    logic [3:0]  pulse, pulse0;

    int n_tests = 0;
    int n_fail  = 0;

    settle_latch_array dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .d_in(d_in), .en_n_in(en_n),
        .d_out(d_out), .valid_out(valid), .capture_pulse(pulse)
    );

    settle_latch_array #(.SETTLE(0), .RESET_VAL(8'h5A)) dut0 (
        .clk(clk), .rst_n(rst_n), .mode(mode0), .d_in(d_in0), .en_n_in(en_n0),
        .d_out(d_out0), .valid_out(valid0), .capture_pulse(pulse0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_tests++;
        if (d_out !== 32'h0 || valid !== 4'h0 || pulse !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state: d_out=%h valid=%b pulse=%b, want 0/0/0", d_out, valid, pulse);
        end
        n_tests++;
        if (d_out0 !== {4{8'h5A}} || valid0 !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_val: d_out0=%h valid0=%b, want 5a5a5a5a/0", d_out0, valid0);
        end
    endtask

    task automatic test_ext_capture();
        logic [7:0] exp_d;
        logic       exp_p;
        d_in[7:0] = 8'hA5;
        en_n[0]   = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp_d = (e >= 6) ? 8'hA5 : 8'h00;
            exp_p = (e == 6);
            n_tests++;
            if (d_out[7:0] !== exp_d || pulse !== {3'b000, exp_p}) begin
                n_fail++;
                $display("FAIL ext_capture edge %0d: d_out0=%h pulse=%b, want %h/%b", e, d_out[7:0], pulse, exp_d, exp_p);
            end
        end
        n_tests++;
        if (valid !== 4'b0001) begin
            n_fail++;
            $display("FAIL ext_valid: valid=%b, want 0001", valid);
        end
    endtask

    task automatic test_unstable();
        en_n[1] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            d_in[15:8] = (((i - 1) / 2) % 2 == 1) ? 8'h22 : 8'h11;
            tick();
            n_tests++;
            if (pulse !== 4'h0 || d_out[15:8] !== 8'h00) begin
                n_fail++;
                $display("FAIL unstable edge %0d: pulse=%b d_out1=%h, want 0/00", i, pulse, d_out[15:8]);
            end
        end
        d_in[15:8] = 8'h22;
        for (int e = 1; e <= 4; e++) begin
            tick();
            n_tests++;
            if (d_out[15:8] !== ((e == 4) ? 8'h22 : 8'h00) || pulse[1] !== (e == 4)) begin
                n_fail++;
                $display("FAIL stable_capture step %0d: d_out1=%h pulse1=%b", e, d_out[15:8], pulse[1]);
            end
        end
        n_tests++;
        if (valid !== 4'b0011) begin
            n_fail++;
            $display("FAIL unstable_valid: valid=%b, want 0011", valid);
        end
    endtask

    task automatic test_early_deassert();
        d_in[23:16] = 8'h77;
        en_n[2]     = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            if (e == 4) en_n[2] = 1'b1;
            tick();
            n_tests++;
            if (pulse[2] !== 1'b0 || d_out[23:16] !== 8'h00) begin
                n_fail++;
                $display("FAIL early_deassert edge %0d: pulse2=%b d_out2=%h, want 0/00", e, pulse[2], d_out[23:16]);
            end
        end
        n_tests++;
        if (valid[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL early_deassert_valid: valid2=%b, want 0", valid[2]);
        end
    endtask

    task automatic test_track_hold();
        logic [7:0] ramp [4];
        logic [7:0] want [4];
        ramp = '{8'h02, 8'h03, 8'h04, 8'h05};
        want = '{8'h02, 8'h03, 8'h03, 8'h03};
        d_in[31:24] = 8'h01;
        en_n[3]     = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            n_tests++;
            if (pulse !== ((e == 6) ? 4'b1000 : 4'b0000)) begin
                n_fail++;
                $display("FAIL track_capture edge %0d: pulse=%b", e, pulse);
            end
        end
        en_n[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_in[31:24] = ramp[i];
            tick();
            n_tests++;
            if (d_out[31:24] !== want[i]) begin
                n_fail++;
                $display("FAIL track_hold step %0d: d_out3=%h, want %h", i, d_out[31:24], want[i]);
            end
        end
        n_tests++;
        if (d_out !== 32'h03_00_22_A5 || valid !== 4'b1011 || pulse !== 4'h0) begin
            n_fail++;
            $display("FAIL lanes_independent: d_out=%h valid=%b pulse=%b, want 030022a5/1011/0000", d_out, valid, pulse);
        end
    endtask

    task automatic test_reset_mid_track();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if (d_out !== 32'h0 || valid !== 4'h0 || pulse !== 4'h0 || d_out0 !== {4{8'h5A}}) begin
            n_fail++;
            $display("FAIL async_reset: d_out=%h valid=%b pulse=%b d_out0=%h", d_out, valid, pulse, d_out0);
        end
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            tick();
            n_tests++;
            if (d_out !== 32'h0 || pulse !== 4'h0 || valid !== 4'h0) begin
                n_fail++;
                $display("FAIL post_reset_hold edge %0d: d_out=%h pulse=%b valid=%b", e, d_out, pulse, valid);
            end
        end
        en_n = 4'hF;
    endtask

    task automatic test_derived();
        logic [7:0] dseq [5];
        logic [7:0] want [5];
        logic [4:0] wpls;
        mode0 = 1'b1;
        for (int e = 1; e <= 3; e++) tick();
        n_tests++;
        if (d_out0 !== {4{8'h5A}} || pulse0 !== 4'h0) begin
            n_fail++;
            $display("FAIL derived_idle: d_out0=%h pulse0=%b", d_out0, pulse0);
        end
        dseq = '{8'h02, 8'h02, 8'h03, 8'h05, 8'h05};
        want = '{8'h5A, 8'h02, 8'h03, 8'h03, 8'h03};
        wpls = 5'b00010;
        for (int i = 0; i < 5; i++) begin
            d_in0[7:0] = dseq[i];
            tick();
            n_tests++;
            if (d_out0[7:0] !== want[i] || pulse0 !== {3'b000, wpls[i]}) begin
                n_fail++;
                $display("FAIL derived step %0d: d_out0=%h pulse0=%b, want %h/%b", i, d_out0[7:0], pulse0, want[i], wpls[i]);
            end
        end
        n_tests++;
        if (d_out0 !== {8'h5A, 8'h5A, 8'h5A, 8'h03} || valid0 !== 4'b0001) begin
            n_fail++;
            $display("FAIL derived_final: d_out0=%h valid0=%b, want 5a5a5a03/0001", d_out0, valid0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        mode  = 1'b0;
        mode0 = 1'b0;
        d_in  = 32'h0;
        d_in0 = 32'hFFFF_FFFF;
        en_n  = 4'hF;
        en_n0 = 4'hF;
        repeat (3) tick();
        test_reset();
        rst_n = 1'b1;
        repeat (2) tick();
        test_ext_capture();
        test_unstable();
        test_early_deassert();
        test_track_hold();
        test_reset_mid_track();
        test_derived();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
